// File: rtl/nrs_seq_gen.sv
// rtl/nrs_seq_gen.sv - NB-IoT NRS pilot generator (Gold sequence + QPSK into a 4-entry pilot file)
//
// Purpose:
//   On an accepted start, latches the cell ID and slot number. It computes c_init
//   for OFDM symbols l=5 and l=6 and runs the length-31 Gold sequence for each
//   symbol. It QPSK-maps the two pilots per symbol into a 4-entry register file and
//   then raises NRS_gen_ready. The channel estimator reads the pilots through
//   nrs_index_addr.
//
// Build option:
//   NRS_GEN_2X_EN - when defined, the Gold LFSRs advance two positions per clock
//                   (STEPS = 911, latency 1825). When undefined, they advance one
//                   position per clock (STEPS = 1822, latency 3647). Pilot values
//                   are identical in both builds.
//
// Ports:
//   clk             in   1      system clock, rising edge
//   rst             in   1      synchronous, active-low reset
//   start           in   1      one-cycle request, samples n_cell_id and ns
//   n_cell_id       in   9      NB-IoT cell ID
//   ns              in   5      slot number
//   busy            out  1      high while generating
//   NRS_gen_ready   out  1      level, pilot register file valid
//   nrs_index_addr  in   2      pilot read address: 0=(l5,m0) 1=(l5,m1) 2=(l6,m0) 3=(l6,m1)
//   nrs_re          out  WIDTH  real part of the addressed pilot, combinational read
//   nrs_im          out  WIDTH  imaginary part of the addressed pilot, combinational read

module nrs_seq_gen #(
    parameter int WIDTH    = 16,
    parameter int NRS_AMP  = 23170,
    parameter int NC       = 1600,
    parameter int M_OFFSET = 109
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [8:0]              n_cell_id,
    input  logic [4:0]              ns,
    output logic                    busy,
    output logic                    NRS_gen_ready,
    input  logic [1:0]              nrs_index_addr,
    output logic signed [WIDTH-1:0] nrs_re,
    output logic signed [WIDTH-1:0] nrs_im
);

    // First captured raw sequence index (m=0, real part).
    localparam int CAP_N    = NC + 2 * M_OFFSET;
    localparam int STEPS_1X = CAP_N + 4;
`ifdef NRS_GEN_2X_EN
    localparam int STEPS    = STEPS_1X / 2;
    localparam int CAP_K    = CAP_N / 2;
`else
    localparam int STEPS    = STEPS_1X;
`endif
    localparam int CNT_W    = $clog2(STEPS + 1);

    localparam logic signed [WIDTH-1:0] AMP_P = WIDTH'(NRS_AMP);
    localparam logic signed [WIDTH-1:0] AMP_N = -AMP_P;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CINIT = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  r_state;
    logic                    r_busy;
    logic                    r_ready;
    logic [8:0]              r_n;
    logic [4:0]              r_ns;
    logic [30:0]             r_cinit5;
    logic [30:0]             r_cinit6;
    logic                    r_sym;
    logic [30:0]             r_x1;
    logic [30:0]             r_x2;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [WIDTH-1:0] r_re [0:3];
    logic signed [WIDTH-1:0] r_im [0:3];

    logic [30:0]             w_x1_nxt;
    logic [30:0]             w_x2_nxt;
    logic                    w_c0;
    logic                    w_cap_en;
    logic                    w_last;
`ifdef NRS_GEN_2X_EN
    logic                    w_c1;
    logic                    w_cap_m;
`else
    logic [1:0]              w_cap_offs;
`endif

    // The arithmetic is carried in 31 bits, so every product and sum wraps modulo 2^31.
    function automatic logic [30:0] calc_cinit(input logic [8:0] n, input logic [4:0] s,
                                               input logic [2:0] l);
        logic [30:0] a;
        logic [30:0] b;
        a = 31'd7 * (31'(s) + 31'd1) + 31'(l) + 31'd1;
        b = 31'd2 * 31'(n) + 31'd1;
        return ((a * b) << 10) + b;
    endfunction

    // Bit i of each register holds x(n+i), and the feedback enters at bit 30.
    function automatic logic [30:0] x1_step(input logic [30:0] x);
        return {x[3] ^ x[0], x[30:1]};
    endfunction

    function automatic logic [30:0] x2_step(input logic [30:0] x);
        return {x[3] ^ x[2] ^ x[1] ^ x[0], x[30:1]};
    endfunction

    function automatic logic signed [WIDTH-1:0] qpsk(input logic b);
        return b ? AMP_N : AMP_P;
    endfunction

    assign w_c0   = r_x1[0] ^ r_x2[0];
    assign w_last = (r_cnt == CNT_W'(STEPS - 1));

`ifdef NRS_GEN_2X_EN
    assign w_x1_nxt = x1_step(x1_step(r_x1));
    assign w_x2_nxt = x2_step(x2_step(r_x2));
    // c(2k+1) is the low bit after one step, which is bit 1 of the current state.
    assign w_c1     = r_x1[1] ^ r_x2[1];
    assign w_cap_en = (r_cnt >= CNT_W'(CAP_K));
    assign w_cap_m  = 1'(r_cnt - CNT_W'(CAP_K));
`else
    assign w_x1_nxt   = x1_step(r_x1);
    assign w_x2_nxt   = x2_step(r_x2);
    assign w_cap_en   = (r_cnt >= CNT_W'(CAP_N));
    // offs[1] selects m, offs[0] selects the re/im half of that pilot.
    assign w_cap_offs = 2'(r_cnt - CNT_W'(CAP_N));
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_n      <= '0;
            r_ns     <= '0;
            r_cinit5 <= '0;
            r_cinit6 <= '0;
            r_sym    <= 1'b0;
            r_x1     <= '0;
            r_x2     <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < 4; i++) begin
                r_re[i] <= '0;
                r_im[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_n     <= n_cell_id;
                        r_ns    <= ns;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= S_CINIT;
                    end
                end
                S_CINIT: begin
                    r_cinit5 <= calc_cinit(r_n, r_ns, 3'd5);
                    r_cinit6 <= calc_cinit(r_n, r_ns, 3'd6);
                    r_sym    <= 1'b0;
                    r_state  <= S_LOAD;
                end
                S_LOAD: begin
                    r_x1    <= 31'd1;
                    r_x2    <= r_sym ? r_cinit6 : r_cinit5;
                    r_cnt   <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_x1 <= w_x1_nxt;
                    r_x2 <= w_x2_nxt;
                    if (w_cap_en) begin
`ifdef NRS_GEN_2X_EN
                        r_re[{r_sym, w_cap_m}] <= qpsk(w_c0);
                        r_im[{r_sym, w_cap_m}] <= qpsk(w_c1);
`else
                        if (w_cap_offs[0])
                            r_im[{r_sym, w_cap_offs[1]}] <= qpsk(w_c0);
                        else
                            r_re[{r_sym, w_cap_offs[1]}] <= qpsk(w_c0);
`endif
                    end
                    if (w_last) begin
                        if (!r_sym) begin
                            r_sym   <= 1'b1;
                            r_state <= S_LOAD;
                        end else begin
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign NRS_gen_ready = r_ready;
    assign nrs_re        = r_re[nrs_index_addr];
    assign nrs_im        = r_im[nrs_index_addr];

endmodule

// File: tb/tb_nrs_seq_gen.sv
// tb/tb_nrs_seq_gen.sv - table-driven bench for nrs_seq_gen

module tb_nrs_seq_gen;

    localparam int NC       = 1600;
    localparam int M_OFFSET = 109;
    localparam int CAP_N    = NC + 2 * M_OFFSET;
    localparam int NBITS    = CAP_N + 4;
`ifdef NRS_GEN_2X_EN
    localparam int LAT = 1825;
`else
    localparam int LAT = 3647;
`endif
    localparam int P2 = (LAT > 2000) ? 2000 : 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [8:0]        n_cell_id;
    logic [4:0]        ns;
    logic              busy;
    logic              NRS_gen_ready;
    logic [1:0]        nrs_index_addr;
    logic signed [15:0] nrs_re;
    logic signed [15:0] nrs_im;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [8:0]  n;
        logic [4:0]  s;
        logic [30:0] c5;
        logic [30:0] c6;
    } vec_t;

    vec_t vt [0:3];

    always #5 clk = ~clk;

    nrs_seq_gen dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .n_cell_id      (n_cell_id),
        .ns             (ns),
        .busy           (busy),
        .NRS_gen_ready  (NRS_gen_ready),
        .nrs_index_addr (nrs_index_addr),
        .nrs_re         (nrs_re),
        .nrs_im         (nrs_im)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic signed [40:0] act,
                       input logic signed [40:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Raw Gold sequence bits at indices CAP_N..CAP_N+3, returned as {re0, im0, re1, im1}.
    function automatic logic [3:0] gold4(input logic [30:0] ci);
        logic       x1 [0:NBITS+30];
        logic       x2 [0:NBITS+30];
        logic [3:0] r;
        for (int i = 0; i < 31; i++) begin
            x1[i] = (i == 0);
            x2[i] = ci[i];
        end
        for (int n = 0; n < NBITS; n++) begin
            x1[n+31] = x1[n+3] ^ x1[n];
            x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
        end
        for (int j = 0; j < 4; j++)
            r[3-j] = x1[CAP_N+j] ^ x2[CAP_N+j];
        return r;
    endfunction

    task automatic check_pilots(input logic [30:0] c5, input logic [30:0] c6, input string tag);
        logic [3:0] b;
        int         mo;
        for (int a = 0; a < 4; a++) begin
            nrs_index_addr = 2'(a);
            #1;
            b  = gold4((a >= 2) ? c6 : c5);
            mo = a % 2;
            chk($sformatf("%s re[%0d]", tag, a), nrs_re, b[3-2*mo] ? -23170 : 23170);
            chk($sformatf("%s im[%0d]", tag, a), nrs_im, b[2-2*mo] ? -23170 : 23170);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int a = 0; a < 4; a++) begin
            nrs_index_addr = 2'(a);
            #1;
            chk($sformatf("%s re[%0d]", tag, a), nrs_re, 0);
            chk($sformatf("%s im[%0d]", tag, a), nrs_im, 0);
        end
    endtask

    task automatic do_start(input logic [8:0] n, input logic [4:0] s);
        start     = 1'b1;
        n_cell_id = n;
        ns        = s;
        tick();
        start     = 1'b0;
        n_cell_id = 9'h1ff;
        ns        = 5'h1f;
    endtask

    // Counts edges until ready rises; a missing ready ends the wait as a failed comparison.
    task automatic wait_ready(input int exp_edges, input string tag);
        int   k;
        int   both;
        logic prev_busy;
        k         = 0;
        both      = 0;
        prev_busy = busy;
        while (NRS_gen_ready !== 1'b1 && k < 6000) begin
            prev_busy = busy;
            tick();
            k++;
            if (busy === 1'b1 && NRS_gen_ready === 1'b1) both++;
        end
        chk({tag, " latency"}, k, exp_edges);
        chk({tag, " busy before ready"}, prev_busy, 1);
        chk({tag, " busy at ready"}, busy, 0);
        chk({tag, " busy&ready overlap"}, both, 0);
    endtask

    initial begin
        vt[0] = '{n: 9'd0,   s: 5'd0,  c5: 31'd13313,     c6: 31'd14337};
        vt[1] = '{n: 9'd503, s: 5'd19, c5: 31'd150551535, c6: 31'd151582703};
        vt[2] = '{n: 9'd10,  s: 5'd3,  c5: 31'd731157,    c6: 31'd752661};
        vt[3] = '{n: 9'd1,   s: 5'd1,  c5: 31'd61443,     c6: 31'd64515};

        rst            = 1'b0;
        start          = 1'b0;
        n_cell_id      = '0;
        ns             = '0;
        nrs_index_addr = '0;

        // Reset held while the request inputs toggle.
        for (int i = 0; i < 50; i++) begin
            start     = i[0];
            n_cell_id = 9'($urandom_range(0, 503));
            ns        = 5'($urandom_range(0, 19));
            tick();
        end
        chk("rst busy", busy, 0);
        chk("rst ready", NRS_gen_ready, 0);
        check_zero("rst pilot");
        start = 1'b0;
        rst   = 1'b1;
        tick();
        chk("idle busy", busy, 0);
        chk("idle ready", NRS_gen_ready, 0);

        // Straight generations from the vector table.
        for (int v = 0; v < 2; v++) begin
            do_start(vt[v].n, vt[v].s);
            chk($sformatf("v%0d busy after start", v), busy, 1);
            chk($sformatf("v%0d ready after start", v), NRS_gen_ready, 0);
            wait_ready(LAT, $sformatf("v%0d", v));
            check_pilots(vt[v].c5, vt[v].c6, $sformatf("v%0d", v));
        end

        // start pulses while busy are ignored.
        do_start(vt[2].n, vt[2].s);
        repeat (9) tick();
        start = 1'b1; n_cell_id = 9'd503; ns = 5'd19;
        tick();
        start = 1'b0;
        chk("ign1 busy", busy, 1);
        repeat (P2 - 11) tick();
        start = 1'b1; n_cell_id = 9'd503; ns = 5'd19;
        tick();
        start = 1'b0;
        chk("ign2 busy", busy, 1);
        chk("ign2 ready", NRS_gen_ready, 0);
        wait_ready(LAT - P2, "ign");
        check_pilots(vt[2].c5, vt[2].c6, "ign");

        // Restart from DONE: ready drops on the start edge and old pilots stay readable.
        do_start(vt[3].n, vt[3].s);
        chk("redo ready drop", NRS_gen_ready, 0);
        chk("redo busy", busy, 1);
        check_pilots(vt[2].c5, vt[2].c6, "stale");
        wait_ready(LAT, "redo");
        check_pilots(vt[3].c5, vt[3].c6, "redo");

        // Reset in the middle of RUN, then a clean restart.
        do_start(vt[1].n, vt[1].s);
        repeat (1000) tick();
        rst = 1'b0;
        tick();
        chk("abort busy", busy, 0);
        chk("abort ready", NRS_gen_ready, 0);
        check_zero("abort pilot");
        rst = 1'b1;
        tick();
        do_start(vt[0].n, vt[0].s);
        wait_ready(LAT, "after abort");
        check_pilots(vt[0].c5, vt[0].c6, "after abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
